movz_imm_splitter: RTL and testbench
====================================

# movz_imm_splitter

Constant-materialization sequencer: accepts a 64-bit immediate and emits the ordered sequence of 16-bit move-wide chunks (one MOVZ, then MOVK beats) that rebuilds it. Each beat carries the `BusB[17:16]` shift selector and the `BusB[15:0]` payload that the ALU MOVZ path decodes. This block is the encoding direction of that path. It sits in the pipeline's immediate-expansion front end and in the ALU bench as a stimulus source. Handshakes are valid/ready on both sides.

## Interface
Parameters:
- SKIP_ZERO, 1, 1: omit all-zero halfwords except when needed for a zero value; 0: always emit all 4 halfwords.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- Reset_L  input  1  one clock; reset is synchronous and active-low.
- in_valid  input  1  in_value is presented.
- in_ready  output  1  block can accept a new value.
- in_value  input  64  immediate to split.
- out_valid  output  1  beat fields are valid.
- out_ready  input  1  consumer accepts the beat.
- out_hw  output  2  halfword index; becomes BusB[17:16].
- out_imm  output  16  halfword payload; becomes BusB[15:0].
- out_keep  output  1  0 = MOVZ (first beat), 1 = MOVK (keep other bits).
- out_last  output  1  final beat of this value.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: register in_value.
  - Build the 4-bit mask: bit i = (value[16i+15:16i] != 0), or all ones when SKIP_ZERO=0.
  - If the mask is 0, force the mask to 4'b0001, so a zero value emits one MOVZ hw=0 imm=0.
  - Go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_hw = index of the lowest set mask bit; out_imm = that halfword.
  - out_keep = 0 on the first beat of the value, 1 on every later beat.
  - out_last = 1 when only one mask bit remains.
- On out_valid&out_ready:
  - Clear the emitted mask bit.
  - If out_last, go to IDLE; otherwise stay in EMIT with the next-lowest halfword.
- Order is strictly ascending hw. Beat count is 1..4.
- Consumer semantics: the first beat zeroes the register and inserts its chunk; each later beat replaces only its chunk. After out_last, the register equals in_value.
- in_value is ignored outside the IDLE acceptance cycle. Changing in_value in EMIT has no effect.

## Timing
- Reset (Reset_L=0 at a clock edge):
  - State goes to IDLE, mask to 0.
  - Outputs: out_valid=0, in_ready=1, out_hw=0, out_imm=0, out_keep=0, out_last=0.
  - Reset applies in any state and abandons an in-flight sequence; no further beats are emitted for it.
- Latency: first beat has out_valid=1 in the cycle after acceptance.
- Throughput: with out_ready held high, one beat per cycle.
- out_* fields are registered and held stable while out_valid&!out_ready. out_valid never drops without a handshake (except on reset).
- After the out_last handshake:
  - in_ready=1 the following cycle.
  - No same-cycle reload: minimum 1 idle cycle between values.
  - A value of N beats occupies N+1 cycles at full throughput.
- in_valid held high during EMIT is not accepted until IDLE.

## Test plan
- Reset: hold Reset_L=0 two cycles with in_valid=1 -> in_ready=1, out_valid=0, all out_* = 0, no acceptance.
- Zero and single chunk, SKIP_ZERO=1:
  - in_value=0 -> one beat: hw=0, imm=0x0000, keep=0, last=1.
  - in_value=0x0000_1234_0000_0000 -> one beat: hw=2, imm=0x1234, keep=0, last=1.
- Full value, out_ready=1: in_value=0xDEAD_0000_BEEF_0001 -> three beats on consecutive cycles:
  - (hw=0, imm=0x0001, keep=0, last=0)
  - (hw=1, imm=0xBEEF, keep=1, last=0)
  - (hw=3, imm=0xDEAD, keep=1, last=1)
  - in_ready=1 the cycle after the last beat.
- Backpressure: same value with out_ready toggling 0,0,1,0,1,1 -> fields stable while stalled; same three beats in order; no beat lost or duplicated.
- SKIP_ZERO=0: in_value=0x0000_0000_0000_00FF -> four beats, hw 0..3, imm 0x00FF,0,0,0, keep 0,1,1,1, last on hw=3.
- Mid-sequence reset and scoreboard:
  - Reset_L=0 during the second beat -> next cycle out_valid=0, in_ready=1.
  - A fresh value then splits correctly.
  - Random 1000 values through an ALU-model reassembler -> reassembled result equals in_value every time.

Source files
------------

// File: rtl/movz_imm_splitter.sv
// ---------------------------------------------------------------------------
// movz_imm_splitter
//
// Splits a 64-bit immediate into an ordered sequence of 16-bit move-wide
// beats: one MOVZ (out_keep=0) followed by zero to three MOVK beats
// (out_keep=1), in strictly ascending halfword order. A consumer that applies
// the beats as MOVZ/MOVK ends up holding exactly in_value after out_last.
//
// Parameters:
//   SKIP_ZERO  1: all-zero halfwords are omitted (a zero value still emits
//                 one MOVZ hw=0 imm=0); 0: all four halfwords are emitted.
//
// Ports:
//   CLK        in   clock, rising edge
//   Reset_L    in   synchronous active-low reset
//   in_valid   in   in_value is presented
//   in_ready   out  block can accept a new value (registered)
//   in_value   in   64-bit immediate to split
//   out_valid  out  beat fields are valid (registered)
//   out_ready  in   consumer accepts the current beat
//   out_hw     out  halfword index (BusB[17:16])
//   out_imm    out  halfword payload (BusB[15:0])
//   out_keep   out  0 = MOVZ (first beat), 1 = MOVK
//   out_last   out  final beat of this value
// ---------------------------------------------------------------------------
module movz_imm_splitter #(
    parameter int SKIP_ZERO = 1
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_hw,
    output logic [15:0] out_imm,
    output logic        out_keep,
    output logic        out_last
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;     // halfwords still to emit, current beat included
    logic [63:0] value_q, value_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_hw_q, out_hw_d;
    logic [15:0] out_imm_q, out_imm_d;
    logic        out_keep_q, out_keep_d;
    logic        out_last_q, out_last_d;

    logic [3:0]  new_mask;
    logic [3:0]  rem_mask;
    logic [1:0]  sel_idx;

    // Halfword selection mask for a freshly accepted value.
    function automatic logic [3:0] build_mask(input logic [63:0] v);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = (SKIP_ZERO == 0) || (v[16*i +: 16] != 16'h0000);
        end
        // A zero value still needs a single MOVZ of halfword 0.
        if (m == 4'b0000) begin
            m = 4'b0001;
        end
        return m;
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        logic [1:0] idx;
        if (m[0])      idx = 2'd0;
        else if (m[1]) idx = 2'd1;
        else if (m[2]) idx = 2'd2;
        else           idx = 2'd3;
        return idx;
    endfunction

    function automatic logic single_bit(input logic [3:0] m);
        return (m != 4'b0000) && ((m & (m - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] idx);
        logic [15:0] h;
        case (idx)
            2'd0:    h = v[15:0];
            2'd1:    h = v[31:16];
            2'd2:    h = v[47:32];
            default: h = v[63:48];
        endcase
        return h;
    endfunction

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        value_d     = value_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_hw_d    = out_hw_q;
        out_imm_d   = out_imm_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        new_mask    = build_mask(in_value);
        rem_mask    = mask_q & ~(4'b0001 << out_hw_q);
        sel_idx     = 2'd0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Load the first beat directly so it is visible the next cycle.
                    sel_idx     = lowest_idx(new_mask);
                    value_d     = in_value;
                    mask_d      = new_mask;
                    out_hw_d    = sel_idx;
                    out_imm_d   = halfword(in_value, sel_idx);
                    out_keep_d  = 1'b0;
                    out_last_d  = single_bit(new_mask);
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                    state_d     = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (out_last_q) begin
                        // Sequence done; the next value can only be taken next cycle.
                        mask_d      = 4'b0000;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        out_hw_d    = 2'd0;
                        out_imm_d   = 16'h0000;
                        out_keep_d  = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        sel_idx    = lowest_idx(rem_mask);
                        mask_d     = rem_mask;
                        out_hw_d   = sel_idx;
                        out_imm_d  = halfword(value_q, sel_idx);
                        out_keep_d = 1'b1;
                        out_last_d = single_bit(rem_mask);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            state_q     <= IDLE;
            mask_q      <= 4'b0000;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_hw_q    <= 2'd0;
            out_imm_q   <= 16'h0000;
            out_keep_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_hw_q    <= out_hw_d;
            out_imm_q   <= out_imm_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
        end
    end

    // Captured immediate; only read while EMIT is active, so it needs no reset.
    always_ff @(posedge CLK) begin
        value_q <= value_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_hw    = out_hw_q;
    assign out_imm   = out_imm_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_movz_imm_splitter.sv
module tb_movz_imm_splitter;

    typedef struct packed {
        logic [1:0]  hw;
        logic [15:0] imm;
        logic        keep;
        logic        last;
    } beat_t;

    logic        CLK;
    logic        rst_n      [2];
    logic        in_valid_s [2];
    logic [63:0] in_value_s [2];
    logic        out_ready_s[2];
    logic        in_ready_w [2];
    logic        out_valid_w[2];
    logic [1:0]  out_hw_w   [2];
    logic [15:0] out_imm_w  [2];
    logic        out_keep_w [2];
    logic        out_last_w [2];

    // Instance 0 skips zero halfwords, instance 1 always emits four.
    movz_imm_splitter #(.SKIP_ZERO(1)) dut_skip (
        .CLK(CLK), .Reset_L(rst_n[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]), .in_value(in_value_s[0]),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]),
        .out_hw(out_hw_w[0]), .out_imm(out_imm_w[0]),
        .out_keep(out_keep_w[0]), .out_last(out_last_w[0])
    );

    movz_imm_splitter #(.SKIP_ZERO(0)) dut_full (
        .CLK(CLK), .Reset_L(rst_n[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]), .in_value(in_value_s[1]),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]),
        .out_hw(out_hw_w[1]), .out_imm(out_imm_w[1]),
        .out_keep(out_keep_w[1]), .out_last(out_last_w[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    beat_t       expq  [2][$];
    beat_t       log_q [2][$];
    logic [63:0] acc_q [2][$];
    logic [63:0] asm_r [2];

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic beat_t mk(input int hw, input logic [15:0] imm, input bit keep, input bit last);
        beat_t b;
        b.hw   = 2'(hw);
        b.imm  = imm;
        b.keep = keep;
        b.last = last;
        return b;
    endfunction

    // Reference: list the halfwords a move-wide sequence must touch, in order.
    function automatic void push_beats(input int d, input logic [63:0] v);
        int idxs[$];
        for (int h = 0; h < 4; h++) begin
            if (d == 1 || v[16*h +: 16] != 16'h0) idxs.push_back(h);
        end
        if (idxs.size() == 0) idxs.push_back(0);
        for (int k = 0; k < idxs.size(); k++) begin
            expq[d].push_back(mk(idxs[k], v[16*idxs[k] +: 16], k != 0, k == idxs.size() - 1));
        end
        acc_q[d].push_back(v);
    endfunction

    // Compare on the falling edge, then predict what the next rising edge does.
    always @(negedge CLK) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                beat_t b;
                int sh;
                b = {out_hw_w[d], out_imm_w[d], out_keep_w[d], out_last_w[d]};
                chk($sformatf("out_valid[%0d]", d), 64'(out_valid_w[d]), 64'(expq[d].size() != 0));
                chk($sformatf("in_ready[%0d]", d), 64'(in_ready_w[d]), 64'(expq[d].size() == 0));
                if (out_valid_w[d] && expq[d].size() != 0) begin
                    chk($sformatf("beat[%0d]", d), 64'(b), 64'(expq[d][0]));
                end
                if (!rst_n[d]) begin
                    expq[d].delete();
                    acc_q[d].delete();
                    asm_r[d] = 64'h0;
                end else begin
                    if (out_valid_w[d] && out_ready_s[d]) begin
                        log_q[d].push_back(b);
                        if (expq[d].size() != 0) void'(expq[d].pop_front());
                        sh = 16 * int'(b.hw);
                        if (!b.keep) asm_r[d] = 64'(b.imm) << sh;
                        else asm_r[d] = (asm_r[d] & ~(64'hFFFF << sh)) | (64'(b.imm) << sh);
                        if (b.last && acc_q[d].size() != 0) begin
                            chk($sformatf("reassembled[%0d]", d), asm_r[d], acc_q[d].pop_front());
                        end
                    end
                    if (in_valid_s[d] && in_ready_w[d]) push_beats(d, in_value_s[d]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // bp: 0 = out_ready high, 1 = pattern 0,0,1,0,1,1, 2 = random
    task automatic run_value(input int d, input logic [63:0] v, input int bp);
        logic pat[6];
        int t;
        int k;
        pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        t = 0;
        while (!in_ready_w[d] && t < 20) begin
            tick();
            t++;
        end
        if (!in_ready_w[d]) chk("accept_timeout", 64'(in_ready_w[d]), 64'd1);
        log_q[d].delete();
        in_valid_s[d] = 1'b1;
        in_value_s[d] = v;
        out_ready_s[d] = 1'b1;
        tick();
        in_valid_s[d] = 1'b0;
        in_value_s[d] = ~v;
        k = 0;
        t = 0;
        while (!(log_q[d].size() != 0 && log_q[d][log_q[d].size()-1].last) && t < 40) begin
            if (bp == 1) out_ready_s[d] = (k < 6) ? pat[k] : 1'b1;
            else if (bp == 2) out_ready_s[d] = 1'($urandom_range(0, 1));
            else out_ready_s[d] = 1'b1;
            tick();
            k++;
            t++;
        end
        if (t >= 40) chk("last_timeout", 64'(t), 64'd0);
        out_ready_s[d] = 1'b1;
        chk("in_ready_after_last", 64'(in_ready_w[d]), 64'd1);
    endtask

    task automatic chk_log(input int d, input string nm, input int n,
                           input beat_t e0, input beat_t e1, input beat_t e2, input beat_t e3);
        beat_t e[4];
        e = '{e0, e1, e2, e3};
        chk({nm, "_count"}, 64'(log_q[d].size()), 64'(n));
        for (int i = 0; i < n && i < log_q[d].size(); i++) begin
            chk($sformatf("%s_beat%0d", nm, i), 64'(log_q[d][i]), 64'(e[i]));
        end
    endtask

    initial begin
        beat_t z;
        logic [63:0] rv;
        z = '0;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            in_valid_s[d] = 1'b1;
            in_value_s[d] = 64'hDEAD_0000_BEEF_0001;
            out_ready_s[d] = 1'b1;
            asm_r[d] = 64'h0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_in_ready[%0d]", d), 64'(in_ready_w[d]), 64'd1);
            chk($sformatf("rst_out_valid[%0d]", d), 64'(out_valid_w[d]), 64'd0);
            chk($sformatf("rst_fields[%0d]", d),
                64'({out_hw_w[d], out_imm_w[d], out_keep_w[d], out_last_w[d]}), 64'd0);
            in_valid_s[d] = 1'b0;
        end
        started = 1'b1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();
        chk("post_rst_out_valid", 64'(out_valid_w[0]), 64'd0);

        run_value(0, 64'h0, 0);
        chk_log(0, "zero", 1, mk(0, 16'h0000, 0, 1), z, z, z);
        run_value(0, 64'h0000_1234_0000_0000, 0);
        chk_log(0, "single", 1, mk(2, 16'h1234, 0, 1), z, z, z);
        run_value(0, 64'hDEAD_0000_BEEF_0001, 0);
        chk_log(0, "full", 3, mk(0, 16'h0001, 0, 0), mk(1, 16'hBEEF, 1, 0), mk(3, 16'hDEAD, 1, 1), z);
        run_value(0, 64'hDEAD_0000_BEEF_0001, 1);
        chk_log(0, "backpressure", 3, mk(0, 16'h0001, 0, 0), mk(1, 16'hBEEF, 1, 0), mk(3, 16'hDEAD, 1, 1), z);
        run_value(1, 64'h0000_0000_0000_00FF, 0);
        chk_log(1, "noskip", 4, mk(0, 16'h00FF, 0, 0), mk(1, 16'h0, 1, 0), mk(2, 16'h0, 1, 0), mk(3, 16'h0, 1, 1));
        run_value(1, 64'h0, 0);
        chk_log(1, "noskip_zero", 4, mk(0, 16'h0, 0, 0), mk(1, 16'h0, 1, 0), mk(2, 16'h0, 1, 0), mk(3, 16'h0, 1, 1));

        // Reset while the second beat is on the bus.
        in_valid_s[0] = 1'b1;
        in_value_s[0] = 64'hDEAD_0000_BEEF_0001;
        out_ready_s[0] = 1'b1;
        tick();
        in_valid_s[0] = 1'b0;
        tick();
        chk("midrst_second_hw", 64'(out_hw_w[0]), 64'd1);
        rst_n[0] = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(out_valid_w[0]), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_w[0]), 64'd1);
        rst_n[0] = 1'b1;
        tick();
        run_value(0, 64'h0000_0000_0055_0000, 0);
        chk_log(0, "after_rst", 1, mk(1, 16'h0055, 0, 1), z, z, z);

        for (int n = 0; n < 1200; n++) begin
            rv = 64'h0;
            for (int h = 0; h < 4; h++) begin
                if ($urandom_range(0, 1) == 1) rv[16*h +: 16] = 16'($urandom);
            end
            run_value((n < 1000) ? 0 : 1, rv, 2);
        end
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
